// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips_ctrl_pkg                                                   |
// | Purpose  : Shared encodings for the pipelined MIPS control unit: opcode   |
// |            and func field values, ALU operation codes and the control     |
// |            bundle carried through the ID/EX stage register.               |
// | Ports    : none (package)                                                 |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package mips_ctrl_pkg;

  // Primary opcodes, instruction [31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes, instruction [5:0]
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Native width of the ALU codes; the top zero-extends to ALUOP_W.
  localparam int ALU_CODE_W = 3;

  typedef enum logic [ALU_CODE_W-1:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd3,
    ALU_SLT = 3'd4,
    ALU_NOR = 3'd5
  } alu_op_e;

  // Control bundle produced in ID. beq/bne are consumed in EX only;
  // memread/memwrite in MEM; memtoreg/regwrite travel on to WB.
  typedef struct packed {
    logic    alusrc;
    logic    dst;
    alu_op_e aluop;
    logic    memread;
    logic    memwrite;
    logic    memtoreg;
    logic    regwrite;
    logic    beq;
    logic    bne;
  } ctrl_bundle_t;

  localparam int CTRL_BUNDLE_W = $bits(ctrl_bundle_t);

endpackage : mips_ctrl_pkg
`default_nettype wire

// File: rtl/mips_ctrl_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips_ctrl_pipe_if                                               |
// | Purpose  : Bus between the datapath and the pipelined control unit.       |
// |            slave  modport: control unit (takes ID fields, drives control) |
// |            master modport: datapath side (drives ID fields, takes control)|
// | Signals  : opcode, func, id_rs, id_rt, ex_zero (to control)                |
// |            pc_write, ifid_write, ifid_flush, pc_sel, ex_alusrc, ex_dst,    |
// |            ex_aluop, mem_memread, mem_memwrite, mem_regwrite,              |
// |            wb_memtoreg, wb_regwrite (from control)                         |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface mips_ctrl_pipe_if #(
  parameter int ALUOP_W    = 3,
  parameter int REG_ADDR_W = 5
);
  logic [5:0]            opcode;
  logic [5:0]            func;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  ex_zero;

  logic                  pc_write;
  logic                  ifid_write;
  logic                  ifid_flush;
  logic [1:0]            pc_sel;
  logic                  ex_alusrc;
  logic                  ex_dst;
  logic [ALUOP_W-1:0]    ex_aluop;
  logic                  mem_memread;
  logic                  mem_memwrite;
  logic                  mem_regwrite;
  logic                  wb_memtoreg;
  logic                  wb_regwrite;

  modport slave (
    input  opcode, func, id_rs, id_rt, ex_zero,
    output pc_write, ifid_write, ifid_flush, pc_sel,
    output ex_alusrc, ex_dst, ex_aluop,
    output mem_memread, mem_memwrite, mem_regwrite,
    output wb_memtoreg, wb_regwrite
  );

  modport master (
    output opcode, func, id_rs, id_rt, ex_zero,
    input  pc_write, ifid_write, ifid_flush, pc_sel,
    input  ex_alusrc, ex_dst, ex_aluop,
    input  mem_memread, mem_memwrite, mem_regwrite,
    input  wb_memtoreg, wb_regwrite
  );
endinterface : mips_ctrl_pipe_if
`default_nettype wire

// File: rtl/mips_ctrl_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips_ctrl_decode                                                |
// | Purpose  : Combinational ID-stage decoder: opcode/func -> control bundle, |
// |            register-usage flags for hazard detection and a jump flag.     |
// | Ports    : opcode, func (in); bundle, uses_rs, uses_rt, jump (out)        |
// | Params   : ENABLE_EXT  1 = also decode ori, slti and nor                   |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter int ENABLE_EXT = 0
) (
  input  logic [5:0]   opcode,
  input  logic [5:0]   func,
  output ctrl_bundle_t bundle,
  output logic         uses_rs,
  output logic         uses_rt,
  output logic         jump
);

  localparam bit EXT_ON = (ENABLE_EXT != 0);

  logic rtype_hit;

  always_comb begin
    bundle    = '0;
    uses_rs   = 1'b0;
    uses_rt   = 1'b0;
    jump      = 1'b0;
    rtype_hit = 1'b0;

    case (opcode)
      OP_RTYPE: begin
        rtype_hit = 1'b1;
        case (func)
          FN_AND:  bundle.aluop = ALU_AND;
          FN_OR:   bundle.aluop = ALU_OR;
          FN_ADD:  bundle.aluop = ALU_ADD;
          FN_SUB:  bundle.aluop = ALU_SUB;
          FN_SLT:  bundle.aluop = ALU_SLT;
          FN_NOR: begin
            if (EXT_ON) bundle.aluop = ALU_NOR;
            else        rtype_hit    = 1'b0;
          end
          default: rtype_hit = 1'b0;
        endcase
        // An unrecognised func leaves the whole bundle at NOP.
        if (rtype_hit) begin
          bundle.dst      = 1'b1;
          bundle.regwrite = 1'b1;
          uses_rs         = 1'b1;
          uses_rt         = 1'b1;
        end
      end
      OP_ANDI: begin
        bundle.alusrc   = 1'b1;
        bundle.regwrite = 1'b1;
        bundle.aluop    = ALU_AND;
        uses_rs         = 1'b1;
      end
      OP_ADDI: begin
        bundle.alusrc   = 1'b1;
        bundle.regwrite = 1'b1;
        bundle.aluop    = ALU_ADD;
        uses_rs         = 1'b1;
      end
      OP_ORI: begin
        if (EXT_ON) begin
          bundle.alusrc   = 1'b1;
          bundle.regwrite = 1'b1;
          bundle.aluop    = ALU_OR;
          uses_rs         = 1'b1;
        end
      end
      OP_SLTI: begin
        if (EXT_ON) begin
          bundle.alusrc   = 1'b1;
          bundle.regwrite = 1'b1;
          bundle.aluop    = ALU_SLT;
          uses_rs         = 1'b1;
        end
      end
      OP_LW: begin
        bundle.alusrc   = 1'b1;
        bundle.aluop    = ALU_ADD;
        bundle.memread  = 1'b1;
        bundle.memtoreg = 1'b1;
        bundle.regwrite = 1'b1;
        uses_rs         = 1'b1;
      end
      OP_SW: begin
        bundle.alusrc   = 1'b1;
        bundle.aluop    = ALU_ADD;
        bundle.memwrite = 1'b1;
        uses_rs         = 1'b1;
        uses_rt         = 1'b1;
      end
      OP_BEQ: begin
        bundle.aluop = ALU_SUB;
        bundle.beq   = 1'b1;
        uses_rs      = 1'b1;
        uses_rt      = 1'b1;
      end
      OP_BNE: begin
        bundle.aluop = ALU_SUB;
        bundle.bne   = 1'b1;
        uses_rs      = 1'b1;
        uses_rt      = 1'b1;
      end
      // Jump is resolved in ID; its bundle stays NOP.
      OP_J:    jump = 1'b1;
      default: ;
    endcase
  end

endmodule : mips_ctrl_decode
`default_nettype wire

// File: rtl/mips_ctrl_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips_ctrl_pipe                                                  |
// | Purpose  : Pipelined control unit for a 5-stage MIPS core. Decodes in ID, |
// |            carries control through ID/EX, EX/MEM, MEM/WB, stalls on       |
// |            load-use hazards and redirects on jumps (ID) / branches (EX).  |
// | Ports    : clk, rst (sync, active high)                                   |
// |            ctl : mips_ctrl_pipe_if.slave (ID fields in, control out)      |
// | Params   : ALUOP_W, REG_ADDR_W (must match ctl), ENABLE_EXT               |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module mips_ctrl_pipe
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W    = 3,
  parameter int REG_ADDR_W = 5,
  parameter int ENABLE_EXT = 0
) (
  input  logic             clk,
  input  logic             rst,
  mips_ctrl_pipe_if.slave  ctl
);

  ctrl_bundle_t          id_bundle;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic                  id_jump;

  ctrl_bundle_t          ex_q;
  logic [REG_ADDR_W-1:0] ex_rt_q;
  logic                  mem_memread_q;
  logic                  mem_memwrite_q;
  logic                  mem_regwrite_q;
  logic                  mem_memtoreg_q;
  logic                  wb_memtoreg_q;
  logic                  wb_regwrite_q;

  logic                  load_use;
  logic                  branch_taken;

  mips_ctrl_decode #(
    .ENABLE_EXT (ENABLE_EXT)
  ) u_decode (
    .opcode  (ctl.opcode),
    .func    (ctl.func),
    .bundle  (id_bundle),
    .uses_rs (id_uses_rs),
    .uses_rt (id_uses_rt),
    .jump    (id_jump)
  );

  // Hazards look at the current EX contents against the instruction in ID.
  // $zero never carries a real dependency, so rt==0 is excluded.
  assign load_use = ex_q.memread && (ex_rt_q != '0) &&
                    ((id_uses_rs && (ex_rt_q == ctl.id_rs)) ||
                     (id_uses_rt && (ex_rt_q == ctl.id_rt)));

  assign branch_taken = (ex_q.beq && ctl.ex_zero) || (ex_q.bne && !ctl.ex_zero);

  // Priority: taken branch > load-use stall > jump. A taken branch
  // overrides any stall and any jump sitting in ID.
  always_comb begin
    ctl.pc_write   = 1'b1;
    ctl.ifid_write = 1'b1;
    ctl.ifid_flush = 1'b0;
    ctl.pc_sel     = 2'b00;
    if (rst) begin
      ctl.ifid_flush = 1'b1;
    end else if (branch_taken) begin
      ctl.pc_sel     = 2'b01;
      ctl.ifid_flush = 1'b1;
    end else if (load_use) begin
      ctl.pc_write   = 1'b0;
      ctl.ifid_write = 1'b0;
    end else if (id_jump) begin
      ctl.pc_sel     = 2'b10;
      ctl.ifid_flush = 1'b1;
    end
  end

  // ID/EX: bubble on stall or taken branch. EX/MEM and MEM/WB always advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q           <= '0;
      ex_rt_q        <= '0;
      mem_memread_q  <= 1'b0;
      mem_memwrite_q <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      wb_memtoreg_q  <= 1'b0;
      wb_regwrite_q  <= 1'b0;
    end else begin
      if (branch_taken || load_use) begin
        ex_q    <= '0;
        ex_rt_q <= '0;
      end else begin
        ex_q    <= id_bundle;
        ex_rt_q <= ctl.id_rt;
      end
      mem_memread_q  <= ex_q.memread;
      mem_memwrite_q <= ex_q.memwrite;
      mem_regwrite_q <= ex_q.regwrite;
      mem_memtoreg_q <= ex_q.memtoreg;
      wb_memtoreg_q  <= mem_memtoreg_q;
      wb_regwrite_q  <= mem_regwrite_q;
    end
  end

  assign ctl.ex_alusrc    = ex_q.alusrc;
  assign ctl.ex_dst       = ex_q.dst;
  assign ctl.ex_aluop     = ALUOP_W'(ex_q.aluop);
  assign ctl.mem_memread  = mem_memread_q;
  assign ctl.mem_memwrite = mem_memwrite_q;
  assign ctl.mem_regwrite = mem_regwrite_q;
  assign ctl.wb_memtoreg  = wb_memtoreg_q;
  assign ctl.wb_regwrite  = wb_regwrite_q;

endmodule : mips_ctrl_pipe
`default_nettype wire

// File: tb/tb_mips_ctrl_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mips_ctrl_pipe                                               |
// | Purpose  : Directed self-checking bench for mips_ctrl_pipe. Two instances |
// |            (ENABLE_EXT = 0 and 1) see identical stimulus.                 |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mips_ctrl_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mips_ctrl_pipe_if #(.ALUOP_W(3), .REG_ADDR_W(5)) bus_b ();
  mips_ctrl_pipe_if #(.ALUOP_W(3), .REG_ADDR_W(5)) bus_x ();

  mips_ctrl_pipe #(.ALUOP_W(3), .REG_ADDR_W(5), .ENABLE_EXT(0)) u_base (
    .clk (clk), .rst (rst), .ctl (bus_b)
  );
  mips_ctrl_pipe #(.ALUOP_W(3), .REG_ADDR_W(5), .ENABLE_EXT(1)) u_ext (
    .clk (clk), .rst (rst), .ctl (bus_x)
  );

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] F_ADD = 6'b100000, F_NOR = 6'b100111, F_NONE = 6'b000000;

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt);
    bus_b.opcode = op; bus_b.func = fn; bus_b.id_rs = rs; bus_b.id_rt = rt;
    bus_x.opcode = op; bus_x.func = fn; bus_x.id_rs = rs; bus_x.id_rt = rt;
    #1;
  endtask

  task automatic set_zero(input logic z);
    bus_b.ex_zero = z;
    bus_x.ex_zero = z;
    #1;
  endtask

  // Inputs change and checks happen 1-2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus_b.ex_zero = 1'b0;
    bus_x.ex_zero = 1'b0;
    drive(OP_R, F_NONE, 5'd0, 5'd0);

    // Reset held two cycles
    tick(); tick();
    chk("rst_ex_aluop",   8'(bus_b.ex_aluop), 8'd0);
    chk("rst_ex_dst",     8'(bus_b.ex_dst), 8'd0);
    chk("rst_mem_regw",   8'(bus_b.mem_regwrite), 8'd0);
    chk("rst_wb_regw",    8'(bus_b.wb_regwrite), 8'd0);
    chk("rst_pc_sel",     8'(bus_b.pc_sel), 8'd0);
    chk("rst_ifid_flush", 8'(bus_b.ifid_flush), 8'd1);
    chk("rst_pc_write",   8'(bus_b.pc_write), 8'd1);
    chk("rst_ifid_write", 8'(bus_b.ifid_write), 8'd1);
    rst = 1'b0;
    #1;
    chk("rel_ifid_flush", 8'(bus_b.ifid_flush), 8'd0);

    // add flows through EX, MEM, WB
    drive(OP_R, F_ADD, 5'd1, 5'd2);
    tick();
    chk("add_ex_aluop", 8'(bus_b.ex_aluop), 8'd2);
    chk("add_ex_dst",   8'(bus_b.ex_dst), 8'd1);
    chk("add_ex_alusrc", 8'(bus_b.ex_alusrc), 8'd0);
    drive(OP_R, F_NONE, 5'd0, 5'd0);
    tick();
    chk("add_mem_regw", 8'(bus_b.mem_regwrite), 8'd1);
    chk("nop_ex_dst",   8'(bus_b.ex_dst), 8'd0);
    tick();
    chk("add_wb_regw",  8'(bus_b.wb_regwrite), 8'd1);
    tick();
    chk("add_wb_clear", 8'(bus_b.wb_regwrite), 8'd0);

    // lw rt=8 then add rs=8: one stall cycle
    drive(OP_LW, F_NONE, 5'd1, 5'd8);
    tick();
    drive(OP_R, F_ADD, 5'd8, 5'd9);
    chk("lu_pc_write",   8'(bus_b.pc_write), 8'd0);
    chk("lu_ifid_write", 8'(bus_b.ifid_write), 8'd0);
    tick();
    chk("lu_bubble_aluop", 8'(bus_b.ex_aluop), 8'd0);
    chk("lu_bubble_dst",   8'(bus_b.ex_dst), 8'd0);
    chk("lu_mem_memread",  8'(bus_b.mem_memread), 8'd1);
    chk("lu_released",     8'(bus_b.pc_write), 8'd1);
    tick();
    chk("lu_add_in_ex",    8'(bus_b.ex_dst), 8'd1);
    chk("lu_add_aluop",    8'(bus_b.ex_aluop), 8'd2);
    chk("lw_wb_memtoreg",  8'(bus_b.wb_memtoreg), 8'd1);
    drive(OP_R, F_NONE, 5'd0, 5'd0);
    tick();

    // lw rt=0 then add rs=0: no stall
    drive(OP_LW, F_NONE, 5'd1, 5'd0);
    tick();
    drive(OP_R, F_ADD, 5'd0, 5'd4);
    chk("lu_r0_no_stall", 8'(bus_b.pc_write), 8'd1);
    tick();

    // sw rs=3 after lw rt=3: stall
    drive(OP_LW, F_NONE, 5'd1, 5'd3);
    tick();
    drive(OP_SW, F_NONE, 5'd3, 5'd5);
    chk("sw_stall", 8'(bus_b.pc_write), 8'd0);
    tick();
    chk("sw_stall_done", 8'(bus_b.pc_write), 8'd1);
    tick();
    chk("sw_ex_alusrc", 8'(bus_b.ex_alusrc), 8'd1);
    chk("sw_ex_aluop",  8'(bus_b.ex_aluop), 8'd2);

    // addi after lw rt=3: stall only when rs matches
    drive(OP_LW, F_NONE, 5'd1, 5'd3);
    tick();
    chk("sw_mem_memwrite", 8'(bus_b.mem_memwrite), 8'd1);
    drive(OP_ADDI, F_NONE, 5'd1, 5'd3);
    chk("addi_rt_no_stall", 8'(bus_b.pc_write), 8'd1);
    drive(OP_ADDI, F_NONE, 5'd3, 5'd7);
    chk("addi_rs_stall", 8'(bus_b.ifid_write), 8'd0);
    tick();
    drive(OP_R, F_NONE, 5'd0, 5'd0);
    tick();

    // beq taken: redirect and bubble
    drive(OP_BEQ, F_NONE, 5'd1, 5'd2);
    tick();
    chk("beq_ex_aluop", 8'(bus_b.ex_aluop), 8'd3);
    set_zero(1'b1);
    drive(OP_R, F_ADD, 5'd1, 5'd2);
    chk("beq_pc_sel",     8'(bus_b.pc_sel), 8'd1);
    chk("beq_ifid_flush", 8'(bus_b.ifid_flush), 8'd1);
    chk("beq_pc_write",   8'(bus_b.pc_write), 8'd1);
    tick();
    set_zero(1'b0);
    chk("beq_bubble_aluop", 8'(bus_b.ex_aluop), 8'd0);
    chk("beq_bubble_dst",   8'(bus_b.ex_dst), 8'd0);

    // bne with zero=1: not taken, no bubble
    drive(OP_BNE, F_NONE, 5'd1, 5'd2);
    tick();
    set_zero(1'b1);
    drive(OP_R, F_ADD, 5'd1, 5'd2);
    chk("bne_pc_sel", 8'(bus_b.pc_sel), 8'd0);
    chk("bne_flush",  8'(bus_b.ifid_flush), 8'd0);
    tick();
    set_zero(1'b0);
    chk("bne_next_aluop", 8'(bus_b.ex_aluop), 8'd2);

    // j in ID with taken beq in EX: branch wins
    drive(OP_BEQ, F_NONE, 5'd1, 5'd2);
    tick();
    set_zero(1'b1);
    drive(OP_J, F_NONE, 5'd0, 5'd0);
    chk("j_vs_beq_pc_sel", 8'(bus_b.pc_sel), 8'd1);
    tick();
    set_zero(1'b0);

    // j alone
    drive(OP_J, F_NONE, 5'd0, 5'd0);
    chk("j_pc_sel", 8'(bus_b.pc_sel), 8'd2);
    chk("j_flush",  8'(bus_b.ifid_flush), 8'd1);
    tick();
    chk("j_ex_dst",   8'(bus_b.ex_dst), 8'd0);
    chk("j_ex_aluop", 8'(bus_b.ex_aluop), 8'd0);

    // Extension decode: nor and ori
    drive(OP_R, F_NOR, 5'd1, 5'd2);
    tick();
    chk("nor_ext_aluop",  8'(bus_x.ex_aluop), 8'd5);
    chk("nor_ext_dst",    8'(bus_x.ex_dst), 8'd1);
    chk("nor_base_aluop", 8'(bus_b.ex_aluop), 8'd0);
    chk("nor_base_dst",   8'(bus_b.ex_dst), 8'd0);
    drive(OP_ORI, F_NONE, 5'd1, 5'd2);
    tick();
    chk("nor_ext_mem_regw",  8'(bus_x.mem_regwrite), 8'd1);
    chk("nor_base_mem_regw", 8'(bus_b.mem_regwrite), 8'd0);
    chk("ori_ext_aluop",  8'(bus_x.ex_aluop), 8'd1);
    chk("ori_ext_alusrc", 8'(bus_x.ex_alusrc), 8'd1);
    chk("ori_base_alusrc", 8'(bus_b.ex_alusrc), 8'd0);

    // Reset mid-operation clears in-flight bundles
    drive(OP_R, F_ADD, 5'd1, 5'd2);
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_ex_dst",   8'(bus_b.ex_dst), 8'd0);
    chk("midrst_mem_regw", 8'(bus_b.mem_regwrite), 8'd0);
    chk("midrst_wb_regw",  8'(bus_x.wb_regwrite), 8'd0);
    chk("midrst_flush",    8'(bus_b.ifid_flush), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mips_ctrl_pipe
`default_nettype wire
